// File: rtl/mult16.sv
// Two-stage pipelined IEEE 754 binary16 multiplier with round-to-nearest-even rounding.
// Subnormal operands and subnormal results are flushed to signed zero.
module mult16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] z,
   output logic        output_ready
);

   localparam logic [15:0] QNAN = 16'h7E00;

   // ---------------- Stage 1: unpack, classify, multiply ----------------
   logic [4:0]  a_exp, b_exp;
   logic [9:0]  a_frac, b_frac;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        s1_nan_d, s1_inf_d, s1_zero_d;
   logic signed [7:0] s1_exp_d;
   logic [21:0] s1_prod_d;

   assign a_exp  = a[14:10];
   assign b_exp  = b[14:10];
   assign a_frac = a[9:0];
   assign b_frac = b[9:0];

   // Exponent 0 covers both true zero and subnormals, which are flushed to zero.
   assign a_nan  = (a_exp == 5'd31) && (a_frac != 10'd0);
   assign b_nan  = (b_exp == 5'd31) && (b_frac != 10'd0);
   assign a_inf  = (a_exp == 5'd31) && (a_frac == 10'd0);
   assign b_inf  = (b_exp == 5'd31) && (b_frac == 10'd0);
   assign a_zero = (a_exp == 5'd0);
   assign b_zero = (b_exp == 5'd0);

   assign s1_nan_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
   assign s1_inf_d  = (a_inf || b_inf) && !s1_nan_d;
   assign s1_zero_d = (a_zero || b_zero) && !s1_nan_d && !s1_inf_d;
   assign s1_exp_d  = $signed({3'b000, a_exp}) + $signed({3'b000, b_exp}) - 8'sd15;
   assign s1_prod_d = {1'b1, a_frac} * {1'b1, b_frac};

   logic              s1_valid;
   logic              s1_sign;
   logic signed [7:0] s1_exp;
   logic [21:0]       s1_prod;
   logic              s1_nan, s1_inf, s1_zero;

   // ---------------- Stage 2: normalize, round, pack ----------------
   logic              norm;
   logic [9:0]        frac_t;
   logic              guard, sticky, round_up;
   logic [10:0]       frac_r;
   logic signed [7:0] exp_r;
   logic [15:0]       z_next;

   assign norm     = s1_prod[21];
   assign frac_t   = norm ? s1_prod[20:11] : s1_prod[19:10];
   assign guard    = norm ? s1_prod[10]    : s1_prod[9];
   assign sticky   = norm ? |s1_prod[9:0]  : |s1_prod[8:0];
   assign round_up = guard && (sticky || frac_t[0]);
   assign frac_r   = {1'b0, frac_t} + {10'd0, round_up};
   // A carry out of the rounded fraction bumps the exponent; the fraction is then zero.
   assign exp_r    = s1_exp + $signed({7'd0, norm}) + $signed({7'd0, frac_r[10]});

   // NOTE: every branch of a combinational block must assign its outputs; the
   // default at the top is what keeps this from inferring a latch.
   always_comb begin
      z_next = {s1_sign, 15'd0};
      if (s1_nan)
         z_next = QNAN;
      else if (s1_inf)
         z_next = {s1_sign, 15'h7C00};
      else if (s1_zero || (exp_r <= 8'sd0))
         z_next = {s1_sign, 15'd0};
      else if (exp_r >= 8'sd31)
         z_next = {s1_sign, 15'h7C00};
      else
         z_next = {s1_sign, exp_r[4:0], (frac_r[10] ? 10'd0 : frac_r[9:0])};
   end

   // NOTE: data registers are reset as well as valid bits, so nothing stale can
   // ever be observed on z after a reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid     <= 1'b0;
         s1_sign      <= 1'b0;
         s1_exp       <= 8'sd0;
         s1_prod      <= 22'd0;
         s1_nan       <= 1'b0;
         s1_inf       <= 1'b0;
         s1_zero      <= 1'b0;
         z            <= 16'h0000;
         output_ready <= 1'b0;
      end else if (en) begin
         // NOTE: non-blocking assignments make both stages update from the
         // values present before the edge, which is what makes this a pipeline.
         s1_valid     <= 1'b1;
         s1_sign      <= a[15] ^ b[15];
         s1_exp       <= s1_exp_d;
         s1_prod      <= s1_prod_d;
         s1_nan       <= s1_nan_d;
         s1_inf       <= s1_inf_d;
         s1_zero      <= s1_zero_d;
         output_ready <= s1_valid;
         if (s1_valid)
            z <= z_next;
      end
   end

endmodule

// File: tb/tb_mult16.sv
// Self-checking bench for mult16: directed vectors plus randomized operands
// compared against an arithmetic binary16 reference model and a two-deep pipeline model.
module tb_mult16;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] a, b;
   logic [15:0] z;
   logic        output_ready;

   int tests = 0;
   int fails = 0;

   // Pipeline model state
   logic        m_s1_valid = 1'b0;
   logic [15:0] m_s1_res   = 16'h0000;
   logic [15:0] m_z        = 16'h0000;
   logic        m_ready    = 1'b0;

   mult16 dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .a            (a),
      .b            (b),
      .z            (z),
      .output_ready (output_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product computed from the exact integer significand product.
   function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      int unsigned ex, ey, fx, fy, p, q, rem, half, shift, k;
      int e;
      logic s, xn, yn, xi, yi, xz, yz;
      ex = x[14:10]; ey = y[14:10]; fx = x[9:0]; fy = y[9:0];
      s  = x[15] ^ y[15];
      xn = (ex == 31) && (fx != 0);  yn = (ey == 31) && (fy != 0);
      xi = (ex == 31) && (fx == 0);  yi = (ey == 31) && (fy == 0);
      xz = (ex == 0);                yz = (ey == 0);
      if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7E00;
      if (xi || yi) return {s, 15'h7C00};
      if (xz || yz) return {s, 15'h0000};
      p     = (1024 + fx) * (1024 + fy);
      k     = (p >= (1 << 21)) ? 21 : 20;
      shift = k - 10;
      q     = p >> shift;
      rem   = p - (q << shift);
      half  = 1 << (shift - 1);
      if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
      e = int'(ex) + int'(ey) - 15 + int'(k) - 20;
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      if (e >= 31) return {s, 15'h7C00};
      if (e <= 0)  return {s, 15'h0000};
      return {s, 5'(e), 10'(q - 1024)};
   endfunction

   task automatic check_outputs(input string tag);
      tests++;
      assert (z === m_z) else begin
         fails++;
         $error("FAIL %s z: got %h expected %h (a=%h b=%h)", tag, z, m_z, a, b);
      end
      tests++;
      assert (output_ready === m_ready) else begin
         fails++;
         $error("FAIL %s ready: got %b expected %b", tag, output_ready, m_ready);
      end
   endtask

   task automatic check_const(input string tag, input logic [15:0] want);
      tests++;
      assert (z === want) else begin
         fails++;
         $error("FAIL %s const: got %h expected %h", tag, z, want);
      end
   endtask

   // Drive one cycle: inputs applied away from the edge, model advanced at the
   // edge, outputs checked on the following falling edge.
   task automatic step(input logic e, input logic [15:0] x, input logic [15:0] y, input string tag);
      en = e; a = x; b = y;
      @(posedge clk);
      if (e) begin
         if (m_s1_valid) m_z = m_s1_res;
         m_ready    = m_s1_valid;
         m_s1_valid = 1'b1;
         m_s1_res   = ref_mul(x, y);
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   function automatic logic [15:0] rand_operand();
      logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                    16'h7E00, 16'h0001, 16'h7BFF, 16'h0400};
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return specials[$urandom_range(0, 7)];
      if (sel < 4)  return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
      return 16'($urandom);
   endfunction

   initial begin
      rst = 1'b0; en = 1'b0; a = 16'h0000; b = 16'h0000;
      #12;
      tests++;
      assert (z === 16'h0000 && output_ready === 1'b0) else begin
         fails++;
         $error("FAIL reset_state: got z=%h ready=%b expected 0000/0", z, output_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 16'h0000, 16'h0000, "idle");

      // Basic 1.0 * 2.0
      step(1'b1, 16'h3C00, 16'h4000, "basic_s");
      step(1'b1, 16'h0000, 16'h0000, "basic_r");
      check_const("basic", 16'h4000);

      // Rounding stream
      step(1'b1, 16'h41F4, 16'h3D6D, "rnd0");
      step(1'b1, 16'h3587, 16'hB587, "rnd1");
      check_const("rnd_a", 16'h440A);
      step(1'b1, 16'h482C, 16'h3380, "rnd2");
      check_const("rnd_b", 16'hAFA3);
      step(1'b1, 16'hBCF4, 16'h0000, "sz0");
      check_const("rnd_c", 16'h3FD2);
      step(1'b1, 16'hBC00, 16'hBCF4, "sz1");
      check_const("neg_zero", 16'h8000);
      step(1'b1, 16'h0000, 16'h3C00, "sz2");
      check_const("sign_pos", 16'h3CF4);
      step(1'b1, 16'h4000, 16'h4000, "sz3");
      check_const("zero_a", 16'h0000);
      step(1'b1, 16'h3C00, 16'h0000, "sz4");
      check_const("four", 16'h4400);

      // Specials
      step(1'b1, 16'h7C00, 16'h3C00, "sp0");
      check_const("zero_b", 16'h0000);
      step(1'b1, 16'h7C00, 16'h0000, "sp1");
      check_const("inf", 16'h7C00);
      step(1'b1, 16'h7E00, 16'h3C00, "sp2");
      check_const("inf_x_zero", 16'h7E00);
      step(1'b1, 16'h7BFF, 16'h4000, "sp3");
      check_const("nan_in", 16'h7E00);
      step(1'b1, 16'h0400, 16'h0400, "sp4");
      check_const("overflow", 16'h7C00);
      step(1'b1, 16'h3C00, 16'h5A5A, "sp5");
      check_const("underflow", 16'h0000);
      step(1'b1, 16'h0000, 16'h0000, "sp6");
      check_const("identity", 16'h5A5A);

      // Stall: sample, freeze three cycles, resume
      step(1'b1, 16'h3C00, 16'h4000, "stall_s");
      for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 16'($urandom), "stall_hold");
      step(1'b1, 16'h0000, 16'h0000, "stall_r");
      check_const("stall", 16'h4000);

      // Randomized traffic with random stalls
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 4) != 0), rand_operand(), rand_operand(), "rand");

      // Asynchronous reset with pipeline full
      step(1'b1, 16'h4200, 16'h4200, "pre_rst0");
      step(1'b1, 16'h4400, 16'h4400, "pre_rst1");
      #2 rst = 1'b0;
      #1;
      tests++;
      assert (z === 16'h0000 && output_ready === 1'b0) else begin
         fails++;
         $error("FAIL async_reset: got z=%h ready=%b expected 0000/0", z, output_ready);
      end
      m_s1_valid = 1'b0; m_s1_res = 16'h0000; m_z = 16'h0000; m_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 16'h3C00, 16'h3E00, "post_rst0");
      step(1'b1, 16'h4000, 16'h4000, "post_rst1");
      check_const("post_rst", 16'h3E00);
      step(1'b1, 16'h0000, 16'h0000, "post_rst2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
